// File: rtl/sram_arb_pkg.sv
// Shared FSM state type and default geometry for the single-port SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } sram_arb_state_t;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts just after ptr and wraps,
// returning a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin front end that serialises NUM_REQ valid/ready clients onto one
// single-port SRAM, one access in flight, with a one-cycle response pulse.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            io_req_valid,
  output logic [NUM_REQ-1:0]            io_req_ready,
  input  logic [NUM_REQ-1:0]            io_req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] io_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] io_req_wdata,
  output logic [NUM_REQ-1:0]            io_resp_valid,
  output logic [DATA_WIDTH-1:0]         io_resp_rdata,
  output logic [ADDR_WIDTH-1:0]         io_sram_addr,
  output logic [DATA_WIDTH-1:0]         io_sram_dataIn,
  output logic                          io_sram_en_we,
  output logic                          io_sram_en_re,
  input  logic [DATA_WIDTH-1:0]         io_sram_dataOut,
  output logic                          io_busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY - 1);

  sram_arb_state_t       state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         id_q, id_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    win_gnt;
  logic [IW-1:0]         win_idx;
  logic                  win_any;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req   (io_req_valid),
    .ptr   (ptr_q),
    .grant (win_gnt),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      id_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_any) begin
          state_d = S_ACCESS;
          ptr_d   = win_idx;
          id_d    = win_idx;
          we_d    = io_req_we[win_idx];
          addr_d  = io_req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = io_req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      S_ACCESS: begin
        cnt_d   = '0;
        state_d = we_q ? S_RESP : S_WAIT;
      end
      // The last wait cycle is the one where the macro's read word is valid.
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d = io_sram_dataOut;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs are forced low while reset is asserted, whatever the state.
  always_comb begin
    io_req_ready  = '0;
    io_resp_valid = '0;
    io_resp_rdata = '0;
    io_sram_en_we = 1'b0;
    io_sram_en_re = 1'b0;
    io_busy       = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_IDLE:   io_req_ready = win_gnt;
        S_ACCESS: begin
          io_busy       = 1'b1;
          io_sram_en_we = we_q;
          io_sram_en_re = !we_q;
        end
        S_WAIT:   io_busy = 1'b1;
        S_RESP: begin
          io_busy             = 1'b1;
          io_resp_valid[id_q] = 1'b1;
          io_resp_rdata       = we_q ? '0 : rdata_q;
        end
        default: ;
      endcase
    end
  end

  assign io_sram_addr   = addr_q;
  assign io_sram_dataIn = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench: two arbiters (read latency 1 and 2) with behavioural SRAMs, driven by
// the same directed and random traffic, checked against a transaction-level model.
module tb_sram_arbiter;
  localparam int NR = 2;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid [NI];
  logic [NR-1:0]    req_ready [NI];
  logic [NR-1:0]    req_we    [NI];
  logic [NR*AW-1:0] req_addr  [NI];
  logic [NR*DW-1:0] req_wdata [NI];
  logic [NR-1:0]    resp_valid[NI];
  logic [DW-1:0]    resp_rdata[NI];
  logic [AW-1:0]    sram_addr [NI];
  logic [DW-1:0]    sram_din  [NI];
  logic [DW-1:0]    sram_dout [NI];
  logic             sram_we   [NI];
  logic             sram_re   [NI];
  logic             busy      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd_pipe [g+1];

    sram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(g+1)) u_dut (
      .clock           (clk),
      .reset           (rst),
      .io_req_valid    (req_valid[g]),
      .io_req_ready    (req_ready[g]),
      .io_req_we       (req_we[g]),
      .io_req_addr     (req_addr[g]),
      .io_req_wdata    (req_wdata[g]),
      .io_resp_valid   (resp_valid[g]),
      .io_resp_rdata   (resp_rdata[g]),
      .io_sram_addr    (sram_addr[g]),
      .io_sram_dataIn  (sram_din[g]),
      .io_sram_en_we   (sram_we[g]),
      .io_sram_en_re   (sram_re[g]),
      .io_sram_dataOut (sram_dout[g]),
      .io_busy         (busy[g])
    );

    // SRAM macro: read word appears g+1 cycles after the en_re cycle.
    always @(posedge clk) begin
      if (sram_we[g]) mem[sram_addr[g]] <= sram_din[g];
      if (sram_re[g]) rd_pipe[0] <= mem[sram_addr[g]];
      for (int i = 1; i <= g; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_dout[g] = rd_pipe[g];
  end

  // Pending requests per requester (what each client presents).
  bit            p_v    [NI][NR];
  bit            p_we   [NI][NR];
  logic [AW-1:0] p_addr [NI][NR];
  logic [DW-1:0] p_wd   [NI][NR];

  // Transaction-level reference model.
  bit            m_act  [NI];
  int            m_t    [NI];
  int            m_id   [NI];
  int            m_last [NI];
  bit            m_we   [NI];
  logic [AW-1:0] m_addr [NI];
  logic [DW-1:0] m_wd   [NI];
  logic [DW-1:0] ref_mem[NI][16];
  bit            written[NI][16];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic int resp_t(int k);
    return m_we[k] ? 2 : 2 + (k + 1);
  endfunction

  function automatic int winner(int k);
    for (int i = 1; i <= NR; i++) begin
      int c = (m_last[k] + i) % NR;
      if (p_v[k][c]) return c;
    end
    return -1;
  endfunction

  function automatic bit work_left();
    for (int k = 0; k < NI; k++) begin
      if (m_act[k]) return 1'b1;
      for (int r = 0; r < NR; r++) if (p_v[k][r]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drive();
    for (int k = 0; k < NI; k++)
      for (int r = 0; r < NR; r++) begin
        req_valid[k][r]           = p_v[k][r];
        req_we[k][r]              = p_we[k][r];
        req_addr[k][r*AW +: AW]   = p_addr[k][r];
        req_wdata[k][r*DW +: DW]  = p_wd[k][r];
      end
  endtask

  task automatic set_both(input int r, input bit we, input int a, input logic [DW-1:0] wd);
    for (int k = 0; k < NI; k++) begin
      p_v[k][r] = 1'b1; p_we[k][r] = we; p_addr[k][r] = AW'(a); p_wd[k][r] = wd;
    end
  endtask

  task automatic step();
    int w [NI];
    drive();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      logic [NR-1:0] e_rdy, e_resp;
      bit e_we, e_re;
      e_rdy = '0; e_resp = '0; e_we = 1'b0; e_re = 1'b0; w[k] = -1;
      if (!m_act[k]) begin
        w[k] = winner(k);
        if (w[k] >= 0) e_rdy[w[k]] = 1'b1;
      end else begin
        if (m_t[k] == 1) begin e_we = m_we[k]; e_re = !m_we[k]; end
        if (m_t[k] == resp_t(k)) e_resp[m_id[k]] = 1'b1;
      end
      check_eq($sformatf("L%0d ready", k+1), req_ready[k], e_rdy);
      check_eq($sformatf("L%0d resp_valid", k+1), resp_valid[k], e_resp);
      check_eq($sformatf("L%0d en_we", k+1), sram_we[k], e_we);
      check_eq($sformatf("L%0d en_re", k+1), sram_re[k], e_re);
      check_eq($sformatf("L%0d busy", k+1), busy[k], m_act[k]);
      check_eq($sformatf("L%0d sram_addr", k+1), sram_addr[k], m_addr[k]);
      check_eq($sformatf("L%0d sram_dataIn", k+1), sram_din[k], m_wd[k]);
      if (e_resp != '0)
        check_eq($sformatf("L%0d rdata a%0d", k+1, m_addr[k]), resp_rdata[k],
                 m_we[k] ? '0 : ref_mem[k][m_addr[k]]);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (m_act[k]) begin
        if (m_t[k] == 1 && m_we[k]) begin
          ref_mem[k][m_addr[k]] = m_wd[k];
          written[k][m_addr[k]] = 1'b1;
        end
        if (m_t[k] == resp_t(k)) m_act[k] = 1'b0;
        else m_t[k]++;
      end else if (w[k] >= 0) begin
        m_act[k] = 1'b1; m_t[k] = 1; m_id[k] = w[k]; m_last[k] = w[k];
        m_we[k] = p_we[k][w[k]]; m_addr[k] = p_addr[k][w[k]]; m_wd[k] = p_wd[k][w[k]];
        p_v[k][w[k]] = 1'b0;
      end
    end
  endtask

  task automatic rst_cycle();
    rst = 1'b1;
    drive();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("L%0d rst ready", k+1), req_ready[k], '0);
      check_eq($sformatf("L%0d rst resp_valid", k+1), resp_valid[k], '0);
      check_eq($sformatf("L%0d rst en_we", k+1), sram_we[k], '0);
      check_eq($sformatf("L%0d rst en_re", k+1), sram_re[k], '0);
      check_eq($sformatf("L%0d rst busy", k+1), busy[k], '0);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      m_act[k] = 1'b0; m_last[k] = NR - 1; m_addr[k] = '0; m_wd[k] = '0;
    end
    rst = 1'b0;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while (work_left() && n < budget) begin step(); n++; end
    check_eq("drain", work_left(), 1'b0);
  endtask

  task automatic refill(input int prob, input bit fill);
    for (int k = 0; k < NI; k++)
      for (int r = 0; r < NR; r++)
        if (fill && !p_v[k][r] && $urandom_range(0, 99) < prob) begin
          int a = $urandom_range(4, 15);
          p_v[k][r]    = 1'b1;
          p_we[k][r]   = !written[k][a] || ($urandom_range(0, 1) == 1);
          p_addr[k][r] = AW'(a);
          p_wd[k][r]   = DW'($urandom);
        end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < NI; k++) begin
      m_act[k] = 1'b0; m_t[k] = 0; m_id[k] = 0; m_last[k] = NR - 1; m_we[k] = 1'b0;
      m_addr[k] = '0; m_wd[k] = '0;
      for (int a = 0; a < 16; a++) begin ref_mem[k][a] = '0; written[k][a] = 1'b0; end
      for (int r = 0; r < NR; r++) begin
        p_v[k][r] = 1'b0; p_we[k][r] = 1'b0; p_addr[k][r] = '0; p_wd[k][r] = '0;
      end
    end

    // Reset with both clients already requesting; req0 must win first.
    set_both(0, 1'b1, 0, 16'h1234);
    set_both(1, 1'b1, 3, 16'h0F0F);
    rst_cycle();
    rst_cycle();
    run_idle(40);

    // Write then read back from the same requester.
    set_both(0, 1'b1, 0, 16'h1234);
    run_idle(20);
    set_both(0, 1'b0, 0, 16'h0);
    run_idle(20);

    // Simultaneous writes, then simultaneous reads.
    set_both(0, 1'b1, 1, 16'hABCD);
    set_both(1, 1'b1, 2, 16'h5555);
    run_idle(40);
    set_both(0, 1'b0, 1, 16'h0);
    set_both(1, 1'b0, 2, 16'h0);
    run_idle(40);

    // Both clients hold valid continuously: grants must alternate.
    for (int i = 0; i < 24; i++) begin refill(100, 1'b1); step(); end
    run_idle(40);

    // Reset two cycles after a read is accepted: no response, data survives.
    set_both(1, 1'b0, 2, 16'h0);
    n = 0;
    while (!m_act[0] && n < 10) begin step(); n++; end
    check_eq("accept before reset", m_act[0], 1'b1);
    step();
    rst_cycle();
    step();
    set_both(1, 1'b0, 2, 16'h0);
    run_idle(40);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin refill(35, 1'b1); step(); end
    run_idle(80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
